// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM encoding and derived-size helpers for the conv window address generator
//
// Contents:
//   state_e    : IDLE / RUN / DONE encoding of the frame FSM
//   calc_out   : valid-convolution output extent (OW, OH) from image extent and kernel size
//   calc_pool  : pooled extent (PW, PH) from output extent and pooling factor (floor)
//   cnt_w      : register width needed to hold 0..max_val (never below 1 bit)

package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_out(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int calc_pool(input int o, input int pool);
    return (pool > 0) ? (o / pool) : 0;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/COUNTER_LAB.sv
// rtl/COUNTER_LAB.sv - wrap counter used for each level of the loop nest
//
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear to 0 (wins over en_i)
//   en_i    : advance by one; wraps from MAX back to 0
//   nxt_o   : value the counter holds after this edge
//   wrap_o  : en_i while at MAX, i.e. enable for the next outer level

module COUNTER_LAB #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == W'(MAX));
  assign wrap_o = en_i && at_max;
  assign nxt_o  = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - read-address generator walking convolution windows with optional 2x2 pool grouping
//
// Ports:
//   iCLK       : clock
//   iRST       : synchronous active-high reset
//   iSTART     : one-cycle frame start request (honoured only when idle)
//   iABORT     : terminate the frame in progress
//   iREADY     : consumer ready; a beat transfers on oVALID && iREADY
//   oVALID     : oADDR carries a valid read address
//   oADDR      : registered read address
//   oWIN_LAST  : last tap of the last channel of a window (accumulator flush)
//   oBUSY      : frame in progress
//   oDONE      : one-cycle pulse after the final beat

module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 14,
  parameter int IMG_H = 18,
  parameter int K     = 3,
  parameter int POOL  = 2,
  parameter int N_CH  = 1,
  parameter int REP   = 112,
  parameter int AW    = 9
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iABORT,
  input  logic          iREADY,
  output logic          oVALID,
  output logic [AW-1:0] oADDR,
  output logic          oWIN_LAST,
  output logic          oBUSY,
  output logic          oDONE
);

  localparam int OW    = calc_out(IMG_W, K);
  localparam int OH    = calc_out(IMG_H, K);
  localparam int PW    = calc_pool(OW, POOL);
  localparam int PH    = calc_pool(OH, POOL);
  localparam int PLANE = IMG_W * IMG_H;

  localparam int KXW = cnt_w(K - 1);
  localparam int KYW = cnt_w(K - 1);
  localparam int CHW = cnt_w(N_CH - 1);
  localparam int RPW = cnt_w(REP - 1);
  localparam int SBW = cnt_w(POOL * POOL - 1);
  localparam int PXW = cnt_w(PW - 1);
  localparam int PYW = cnt_w(PH - 1);

  if (K < 1 || K > 7) begin : g_bad_k
    $fatal(1, "conv_window_addr_gen: K must be in 1..7");
  end
  if (K > IMG_W || K > IMG_H) begin : g_bad_kernel_fit
    $fatal(1, "conv_window_addr_gen: kernel larger than the image");
  end
  if (POOL < 1 || POOL > 2) begin : g_bad_pool
    $fatal(1, "conv_window_addr_gen: POOL must be 1 or 2");
  end
  if (PW < 1 || PH < 1) begin : g_bad_pooled_size
    $fatal(1, "conv_window_addr_gen: pooled output extent is zero");
  end
  if (AW < $clog2(N_CH * PLANE)) begin : g_bad_aw
    $fatal(1, "conv_window_addr_gen: AW too small for N_CH*IMG_W*IMG_H");
  end

  state_e state_q;
  state_e state_d;

  logic xfer;
  logic clr;
  logic frame_end;

  logic [KXW-1:0] kx_n;
  logic [KYW-1:0] ky_n;
  logic [CHW-1:0] ch_n;
  logic [RPW-1:0] rep_unused;
  logic [SBW-1:0] sub_n;
  logic [PXW-1:0] px_n;
  logic [PYW-1:0] py_n;

  logic kx_wrap;
  logic ky_wrap;
  logic ch_wrap;
  logic rep_wrap;
  logic sub_wrap;
  logic px_wrap;
  logic py_wrap;

  logic [AW-1:0] addr_d;
  logic [AW-1:0] addr_q;
  logic          win_d;
  logic          win_q;

  assign xfer = (state_q == ST_RUN) && iREADY;
  // Abort clears the whole nest so the next start always begins at address 0.
  assign clr  = (state_q == ST_RUN) && iABORT;

  // Innermost to outermost; each wrap enables the next level out.
  COUNTER_LAB #(.MAX(K - 1),        .W(KXW)) u_kx (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(xfer),     .nxt_o(kx_n),       .wrap_o(kx_wrap));
  COUNTER_LAB #(.MAX(K - 1),        .W(KYW)) u_ky (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(kx_wrap),  .nxt_o(ky_n),       .wrap_o(ky_wrap));
  COUNTER_LAB #(.MAX(N_CH - 1),     .W(CHW)) u_ch (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(ky_wrap),  .nxt_o(ch_n),       .wrap_o(ch_wrap));
  COUNTER_LAB #(.MAX(REP - 1),      .W(RPW)) u_rep (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(ch_wrap),  .nxt_o(rep_unused), .wrap_o(rep_wrap));
  COUNTER_LAB #(.MAX(POOL*POOL - 1), .W(SBW)) u_sub (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(rep_wrap), .nxt_o(sub_n),      .wrap_o(sub_wrap));
  COUNTER_LAB #(.MAX(PW - 1),       .W(PXW)) u_px (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(sub_wrap), .nxt_o(px_n),       .wrap_o(px_wrap));
  COUNTER_LAB #(.MAX(PH - 1),       .W(PYW)) u_py (
    .clk_i(iCLK), .rst_i(iRST), .clr_i(clr), .en_i(px_wrap),  .nxt_o(py_n),       .wrap_o(py_wrap));

  // Outermost wrap can only fire when every inner level wraps on the same transfer.
  assign frame_end = py_wrap;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (iSTART) state_d = ST_RUN;
      ST_RUN: begin
        if (iABORT) begin
          state_d = ST_IDLE;
        end else if (frame_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address is formed from the counters' next values and registered, so it
  // lines up with the counter state and holds while the consumer stalls.
  // Every product has a parameter as one operand.
  always_comb begin
    logic [AW-1:0] sx;
    logic [AW-1:0] sy;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    sx     = AW'(sub_n) % AW'(POOL);
    sy     = AW'(sub_n) / AW'(POOL);
    row    = AW'(py_n) * AW'(POOL) + sy + AW'(ky_n);
    col    = AW'(px_n) * AW'(POOL) + sx + AW'(kx_n);
    addr_d = AW'(ch_n) * AW'(PLANE) + row * AW'(IMG_W) + col;
    win_d  = (ch_n == CHW'(N_CH - 1)) && (ky_n == KYW'(K - 1)) && (kx_n == KXW'(K - 1));
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      addr_q <= '0;
      win_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      win_q  <= win_d;
    end
  end

  assign oVALID    = (state_q == ST_RUN);
  assign oBUSY     = (state_q == ST_RUN);
  assign oDONE     = (state_q == ST_DONE);
  assign oADDR     = addr_q;
  assign oWIN_LAST = win_q;

endmodule

// File: doc/conv_window_addr_gen.md
CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 14, input feature-map width in words.
REQ-002 SHALL have parameter IMG_H, default 18, input feature-map height in words.
REQ-003 SHALL have parameter K, default 3, square kernel size (1..7).
REQ-004 SHALL have parameter POOL, default 2, pooling factor: 1 = none, 2 = 2x2 sub-position grouping.
REQ-005 SHALL have parameter N_CH, default 1, input channels; channel c is based at c*IMG_W*IMG_H.
REQ-006 SHALL have parameter REP, default 112, repeats of each window (one per output filter).
REQ-007 SHALL have parameter AW, default 9, address width, with AW >= clog2(N_CH*IMG_W*IMG_H).
REQ-008 SHALL have ports iCLK in 1 (clock) and iRST in 1 (reset); one clock; reset is synchronous and active-high.
REQ-009 SHALL have port iSTART in 1, a one-cycle request to begin a frame.
REQ-010 SHALL have port iABORT in 1, which terminates a frame in progress.
REQ-011 SHALL have port iREADY in 1, consumer ready.
REQ-012 SHALL have port oVALID out 1, meaning oADDR is valid.
REQ-013 SHALL have port oADDR out AW, read address.
REQ-014 SHALL have port oWIN_LAST out 1, marking the last tap of the last channel of one window (accumulator flush).
REQ-015 SHALL have port oBUSY out 1, high from accepted start until done or abort.
REQ-016 SHALL have port oDONE out 1, a one-cycle pulse after the final beat.

Function
REQ-017 Derived sizes SHALL be OW=IMG_W-K+1, OH=IMG_H-K+1, PW=OW/POOL, PH=OH/POOL (floor).
REQ-018 Iteration order SHALL be, outer to inner: py(0..PH-1), px(0..PW-1), sub(0..POOL*POOL-1; sx=sub%POOL, sy=sub/POOL), rep(0..REP-1), ch(0..N_CH-1), ky(0..K-1), kx(0..K-1).
REQ-019 Each beat SHALL produce oADDR = ch*IMG_W*IMG_H + (py*POOL+sy+ky)*IMG_W + (px*POOL+sx+kx).
REQ-020 Multiplications SHALL be by parameters only; no variable-by-variable multiplier.
REQ-021 The FSM SHALL have states IDLE, RUN, DONE; iSTART in IDLE SHALL move to RUN, and oVALID with the first address SHALL assert on the next cycle.
REQ-022 A beat SHALL transfer when oVALID && iREADY; counters advance only on a transfer.
REQ-023 With oVALID high and iREADY low, oADDR and oWIN_LAST SHALL hold stable.
REQ-024 oWIN_LAST SHALL be 1 when ch=N_CH-1, ky=K-1 and kx=K-1, and 0 otherwise.
REQ-025 The final beat's transfer SHALL move the FSM from RUN to DONE; DONE SHALL assert oDONE for one cycle, then return to IDLE.
REQ-026 Total beats per frame SHALL be PH*PW*POOL*POOL*REP*N_CH*K*K.
REQ-027 iSTART while oBUSY SHALL be ignored.
REQ-028 iABORT in RUN SHALL return the FSM to IDLE on the next cycle, with oVALID=0, no oDONE, and counters cleared; iABORT in IDLE SHALL have no effect.
REQ-029 If iSTART and iABORT are both high in IDLE, start SHALL win.
REQ-030 A start SHALL be accepted in the cycle after oDONE.
REQ-031 oADDR SHALL be registered, driving no combinational path from iREADY to oADDR.

Reset
REQ-032 iRST high SHALL force state IDLE, all counters to 0, and oVALID=0, oADDR=0, oWIN_LAST=0, oBUSY=0, oDONE=0, including mid-frame.
REQ-033 Reset SHALL take priority over iSTART, iABORT and iREADY.

Structure
REQ-034 The derived sizes (OW, OH, PW, PH) and the FSM state encoding SHALL reside in the shared package conv_pkg.
REQ-035 Each loop level SHALL use the existing wrap counter COUNTER_LAB (enable in, wrap-enable out); the chained wrap enables form the nest.
REQ-036 Elaboration SHALL fail if K>IMG_W, K>IMG_H, PW=0, PH=0, or AW is too small.

Verification
REQ-037 Geometry check: IMG_W=IMG_H=6, K=3, POOL=2, N_CH=1, REP=1, iREADY=1 -> first 9 addresses 0,1,2,6,7,8,12,13,14; beat 10 = 1; 144 beats; oDONE one cycle after beat 144.
REQ-038 Multi-channel: same geometry with N_CH=2 -> beats 10..18 = 36,37,38,42,43,44,48,49,50; oWIN_LAST on beat 18.
REQ-039 Backpressure: random iREADY at 50% -> address sequence identical to REQ-037 and addresses stable while stalled.
REQ-040 No pooling: POOL=1, IMG_W=5, IMG_H=4, K=3 -> 6 windows x 9 = 54 beats; window 2 starts at address 1; window 4 starts at address 5.
REQ-041 Abort and restart: iABORT at beat 20 -> oVALID=0 next cycle and no oDONE; iSTART then gives a fresh sequence from address 0.
REQ-042 Reset and ignored start: iRST at beat 30 -> all outputs 0 next cycle; iSTART mid-frame does not disturb the sequence.
